qsfp_dom_scanner: RTL and testbench

QSFP_DOM_SCANNER -- requirements
Module: qsfp_dom_scanner

---
 rtl/qsfp_dom_pkg.sv | 44 ++++
 rtl/qsfp_dom_regfile.sv | 57 +++++
 rtl/qsfp_dom_scanner.sv | 147 ++++++++++++++
 tb/tb_qsfp_dom_scanner.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsfp_dom_pkg.sv
`default_nettype none
// ============================================================================
// Package : qsfp_dom_pkg
// Brief   : Shared constants, byte map and FSM state type for the QSFP DOM
//           scanner and its word storage.
// Rev     : 1.0  initial release
// ============================================================================
package qsfp_dom_pkg;

   localparam int SLOTS_PER_MODULE = 6;
   localparam int CYCLES_PER_WORD  = 5;

   // MSB byte of each monitored word; the LSB always sits at MSB + 1
   localparam logic [7:0] BYTE_TEMP_MSB = 8'd22;
   localparam logic [7:0] BYTE_VCC_MSB  = 8'd26;
   localparam logic [7:0] BYTE_RX1_MSB  = 8'd34;
   localparam logic [7:0] BYTE_RX2_MSB  = 8'd36;
   localparam logic [7:0] BYTE_RX3_MSB  = 8'd38;
   localparam logic [7:0] BYTE_RX4_MSB  = 8'd40;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_HI  = 3'd1,
      CAP_HI = 3'd2,
      RD_LO  = 3'd3,
      CAP_LO = 3'd4,
      WRITE  = 3'd5
   } scan_state_t;

   // Slot number -> MSB byte offset inside the per-module shadow page
   function automatic logic [7:0] slot_msb_byte(input logic [2:0] slot);
      case (slot)
         3'd0:    return BYTE_TEMP_MSB;
         3'd1:    return BYTE_VCC_MSB;
         3'd2:    return BYTE_RX1_MSB;
         3'd3:    return BYTE_RX2_MSB;
         3'd4:    return BYTE_RX3_MSB;
         3'd5:    return BYTE_RX4_MSB;
         default: return 8'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/qsfp_dom_regfile.sv
`default_nettype none
// ============================================================================
// Module : qsfp_dom_regfile
// Brief  : Per-module DOM word storage (QSFP_COUNT x 6 words) with a single
//          write port from the scanner and a registered host read port.
// Rev    : 1.0  initial release
// ============================================================================
module qsfp_dom_regfile #(
   parameter int QSFP_COUNT = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_we,
   input  logic [$clog2(QSFP_COUNT)-1:0]  i_wmod,
   input  logic [2:0]                     i_wslot,
   input  logic [15:0]                    i_wdata,
   input  logic [$clog2(QSFP_COUNT)+2:0]  i_raddr,
   output logic [15:0]                    o_rdata
);
   import qsfp_dom_pkg::*;

   localparam int MW    = $clog2(QSFP_COUNT);
   localparam int DEPTH = QSFP_COUNT * SLOTS_PER_MODULE;
   localparam int IDX_W = $clog2(DEPTH);

   logic [15:0]      r_mem [DEPTH];
   logic [15:0]      r_rdata;
   logic [IDX_W-1:0] w_widx;
   logic [IDX_W-1:0] w_ridx;
   logic             w_rvalid;

   // Flatten {module, slot} addresses; slots 6/7 and absent modules read zero
   always_comb begin
      w_widx   = IDX_W'(int'(i_wmod) * SLOTS_PER_MODULE + int'(i_wslot));
      w_ridx   = IDX_W'(int'(i_raddr[MW+2:3]) * SLOTS_PER_MODULE + int'(i_raddr[2:0]));
      w_rvalid = (i_raddr[2:0] < 3'(SLOTS_PER_MODULE)) && (int'(i_raddr[MW+2:3]) < QSFP_COUNT);
   end

   // Word storage, one word written per scanner WRITE cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[w_widx] <= i_wdata;
      end
   end

   // Registered host read; a same-cycle write is seen on the following read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rdata <= '0;
      else     r_rdata <= w_rvalid ? r_mem[w_ridx] : 16'h0000;
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/qsfp_dom_scanner.sv
`default_nettype none
// ============================================================================
// Module : qsfp_dom_scanner
// Brief  : Walks the I2C poller shadow memory after each refresh, collects
//          temperature, Vcc and four RX-power words per QSFP module, stores
//          them for host reads and raises per-module threshold alarms.
// Rev    : 1.0  initial release
// ============================================================================
module qsfp_dom_scanner #(
   parameter int                 QSFP_COUNT = 2,
   parameter logic signed [15:0] TEMP_LIMIT = 16'sh4600,
   parameter logic [15:0]        RXPOW_MIN  = 16'd100
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           updated,
   output logic [$clog2(QSFP_COUNT)+7:0]  readAddress,
   input  logic [7:0]                     readData,
   input  logic [$clog2(QSFP_COUNT)+2:0]  sysReadAddr,
   output logic [15:0]                    sysReadData,
   output logic [QSFP_COUNT-1:0]          alarm,
   output logic                           scanDone,
   output logic [15:0]                    scanCount
);
   import qsfp_dom_pkg::*;

   localparam int MW = $clog2(QSFP_COUNT);

   scan_state_t             r_state;
   scan_state_t             w_state_nxt;
   logic [MW-1:0]           r_mod;
   logic [2:0]              r_slot;
   logic [7:0]              r_hi;
   logic                    r_pending;
   logic [QSFP_COUNT-1:0]   r_acc;
   logic [QSFP_COUNT-1:0]   r_alarm;
   logic [MW+7:0]           r_read_addr;
   logic                    r_scan_done;
   logic [15:0]             r_scan_count;

   logic                    w_start;
   logic                    w_last;
   logic [15:0]             w_word;
   logic                    w_word_alarm;
   logic [QSFP_COUNT-1:0]   w_acc_nxt;

   assign w_start = (r_state == IDLE) && (updated || r_pending);
   assign w_last  = (r_mod == MW'(QSFP_COUNT - 1)) && (r_slot == 3'(SLOTS_PER_MODULE - 1));
   assign w_word  = {r_hi, readData};

   // Threshold compare on the word being written and alarm accumulation
   always_comb begin
      w_word_alarm = 1'b0;
      if (r_slot == 3'd0)      w_word_alarm = ($signed(w_word) > TEMP_LIMIT);
      else if (r_slot >= 3'd2) w_word_alarm = (w_word < RXPOW_MIN);
      w_acc_nxt = r_acc;
      if (r_state == WRITE) w_acc_nxt[r_mod] = r_acc[r_mod] | w_word_alarm;
   end

   // Next-state logic: five states per word, back to IDLE after the last word
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (updated || r_pending) w_state_nxt = RD_HI;
         RD_HI:   w_state_nxt = CAP_HI;
         CAP_HI:  w_state_nxt = RD_LO;
         RD_LO:   w_state_nxt = CAP_LO;
         CAP_LO:  w_state_nxt = WRITE;
         WRITE:   w_state_nxt = w_last ? IDLE : RD_HI;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Datapath: addressing, byte capture, word cursor, alarms and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mod        <= '0;
         r_slot       <= '0;
         r_hi         <= '0;
         r_pending    <= 1'b0;
         r_acc        <= '0;
         r_alarm      <= '0;
         r_read_addr  <= '0;
         r_scan_done  <= 1'b0;
         r_scan_count <= '0;
      end else begin
         r_scan_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_mod     <= '0;
                  r_slot    <= '0;
                  r_acc     <= '0;
                  r_pending <= 1'b0;
               end
            end
            RD_HI: r_read_addr <= {r_mod, slot_msb_byte(r_slot)};
            RD_LO: begin
               r_hi        <= readData;
               r_read_addr <= {r_mod, slot_msb_byte(r_slot) | 8'd1};
            end
            WRITE: begin
               r_acc <= w_acc_nxt;
               if (w_last) begin
                  r_alarm      <= w_acc_nxt;
                  r_scan_done  <= 1'b1;
                  r_scan_count <= r_scan_count + 16'd1;
               end else if (r_slot == 3'(SLOTS_PER_MODULE - 1)) begin
                  r_slot <= '0;
                  r_mod  <= r_mod + MW'(1);
               end else begin
                  r_slot <= r_slot + 3'd1;
               end
            end
            default: ;
         endcase
         // Refreshes during a scan collapse into one follow-up scan
         if (updated && (r_state != IDLE)) r_pending <= 1'b1;
      end
   end

   qsfp_dom_regfile #(
      .QSFP_COUNT (QSFP_COUNT)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .i_we    (r_state == WRITE),
      .i_wmod  (r_mod),
      .i_wslot (r_slot),
      .i_wdata (w_word),
      .i_raddr (sysReadAddr),
      .o_rdata (sysReadData)
   );

   assign readAddress = r_read_addr;
   assign alarm       = r_alarm;
   assign scanDone    = r_scan_done;
   assign scanCount   = r_scan_count;

endmodule
`default_nettype wire

// File: tb/tb_qsfp_dom_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_qsfp_dom_scanner
// Brief  : Self-checking bench for qsfp_dom_scanner (QSFP_COUNT = 2) with a
//          scan-level reference model and directed scenarios.
// Rev    : 1.0  initial release
// ============================================================================
module tb_qsfp_dom_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        updated = 1'b0;
   logic [8:0]  readAddress;
   logic [7:0]  readData = 8'h00;
   logic [3:0]  sysReadAddr = 4'h0;
   logic [15:0] sysReadData;
   logic [1:0]  alarm;
   logic        scanDone;
   logic [15:0] scanCount;

   int n_cmp  = 0;
   int n_fail = 0;

   qsfp_dom_scanner #(.QSFP_COUNT(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .updated     (updated),
      .readAddress (readAddress),
      .readData    (readData),
      .sysReadAddr (sysReadAddr),
      .sysReadData (sysReadData),
      .alarm       (alarm),
      .scanDone    (scanDone),
      .scanCount   (scanCount)
   );

   always #5 clk = ~clk;

   // Poller shadow memory: data one cycle after the address
   logic [7:0] mem [0:511];
   always @(posedge clk) readData <= mem[readAddress];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] msb_off(input int s);
      if (s == 0) return 8'd22;
      if (s == 1) return 8'd26;
      return 8'(34 + 2 * (s - 2));
   endfunction

   function automatic logic [15:0] shadow_word(input int m, input int s);
      return {mem[m*256 + int'(msb_off(s))], mem[m*256 + int'(msb_off(s)) + 1]};
   endfunction

   function automatic logic mod_alarm(input int m);
      logic a;
      a = ($signed(shadow_word(m, 0)) > $signed(16'sh4600));
      for (int s = 2; s < 6; s++) if (shadow_word(m, s) < 16'd100) a = 1'b1;
      return a;
   endfunction

   task automatic set_word(input int m, input int s, input logic [15:0] v);
      mem[m*256 + int'(msb_off(s))]     = v[15:8];
      mem[m*256 + int'(msb_off(s)) + 1] = v[7:0];
   endtask

   // ---------------- scan-level reference model ----------------
   bit          m_active, m_pend, m_done, m_rd_ok;
   int          m_t, m_start;
   logic [15:0] e_count, e_rd;
   logic [15:0] e_words [2][6];
   logic [1:0]  e_alarm;
   logic [8:0]  e_raddr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 0; m_pend = 0; m_done = 0; m_rd_ok = 0;
         m_t = 0; m_start = 0;
         e_count = 0; e_rd = 0; e_alarm = 0; e_raddr = 0;
         for (int m = 0; m < 2; m++) for (int s = 0; s < 6; s++) e_words[m][s] = 0;
      end else begin
         m_t++;
         m_done  = 0;
         m_rd_ok = !m_active;
         e_rd = (sysReadAddr[2:0] >= 3'd6) ? 16'h0000
                : e_words[int'(sysReadAddr[3])][int'(sysReadAddr[2:0])];
         if (m_active) begin
            int d, k, ph;
            d  = m_t - m_start;
            k  = (d - 1) / 5;
            ph = (d - 1) % 5;
            if (updated) m_pend = 1;
            if (ph == 0)      e_raddr = {1'(k / 6), msb_off(k % 6)};
            else if (ph == 2) e_raddr = {1'(k / 6), msb_off(k % 6) + 8'd1};
            if (d == 60) begin
               m_done   = 1;
               m_active = 0;
               e_count  = e_count + 16'd1;
               e_alarm  = {mod_alarm(1), mod_alarm(0)};
               for (int m = 0; m < 2; m++)
                  for (int s = 0; s < 6; s++) e_words[m][s] = shadow_word(m, s);
            end
         end else if (updated || m_pend) begin
            m_active = 1;
            m_start  = m_t;
            m_pend   = 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst) begin
         check("scanDone", 32'(scanDone), 32'(m_done));
         check("scanCount", 32'(scanCount), 32'(e_count));
         check("alarm", 32'(alarm), 32'(e_alarm));
         check("readAddress", 32'(readAddress), 32'(e_raddr));
         if (m_rd_ok) check("sysReadData", 32'(sysReadData), 32'(e_rd));
      end
   end

   // ---------------- directed scenarios ----------------
   task automatic pulse_updated();
      @(negedge clk) updated = 1'b1;
      @(negedge clk) updated = 1'b0;
   endtask

   task automatic wait_done(input string name, output int n);
      n = 0;
      while (!scanDone && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!scanDone) check({name, "_timeout"}, 32'(n), 32'd61);
   endtask

   task automatic run_scan(input string name);
      int n;
      pulse_updated();
      wait_done(name, n);
   endtask

   task automatic host_read(input logic [3:0] a, input string name, input logic [15:0] exp);
      @(negedge clk) sysReadAddr = a;
      @(negedge clk) check(name, 32'(sysReadData), 32'(exp));
   endtask

   initial begin
      int n, gap;
      logic [8:0] q[$];
      logic [8:0] last;

      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      for (int m = 0; m < 2; m++) begin
         set_word(m, 0, 16'h1900);
         set_word(m, 1, 16'h8000);
         for (int s = 2; s < 6; s++) set_word(m, s, 16'h0400);
      end

      // Reset state
      #1 rst = 1'b1;
      #1;
      check("rst_readAddress", 32'(readAddress), 32'd0);
      check("rst_sysReadData", 32'(sysReadData), 32'd0);
      check("rst_alarm", 32'(alarm), 32'd0);
      check("rst_scanDone", 32'(scanDone), 32'd0);
      check("rst_scanCount", 32'(scanCount), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // First scan: latency and readAddress order
      @(negedge clk) updated = 1'b1;
      n = 0;
      last = readAddress;
      @(negedge clk) updated = 1'b0;
      n = 1;
      while (!scanDone && n < 200) begin
         @(negedge clk);
         n++;
         if (readAddress != last) begin
            q.push_back(readAddress);
            last = readAddress;
         end
      end
      check("scan_latency", 32'(n), 32'd61);
      check("addr_count", 32'(q.size()), 32'd24);
      if (q.size() == 24) begin
         check("addr0", 32'(q[0]), 32'd22);
         check("addr1", 32'(q[1]), 32'd23);
         check("addr2", 32'(q[2]), 32'd26);
         check("addr3", 32'(q[3]), 32'd27);
         check("addr4", 32'(q[4]), 32'd34);
         check("addr11", 32'(q[11]), 32'd41);
         check("addr12", 32'(q[12]), 32'h116);
         check("addr23", 32'(q[23]), 32'h129);
      end
      check("scan1_alarm", 32'(alarm), 32'd0);
      check("scan1_count", 32'(scanCount), 32'd1);
      host_read(4'h0, "slot0_temp", 16'h1900);
      host_read(4'h2, "slot2_rx", 16'h0400);

      // Module 1 over temperature and lane 3 dark
      set_word(1, 0, 16'h4601);
      set_word(1, 4, 16'h0063);
      run_scan("alarm_scan");
      check("alarm_set", 32'(alarm), 32'b10);
      host_read(4'h8, "m1_temp", 16'h4601);
      host_read(4'hC, "m1_lane3", 16'h0063);

      // Reset at word 7 of a scan
      pulse_updated();
      repeat (35) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_readAddress", 32'(readAddress), 32'd0);
      check("midrst_sysReadData", 32'(sysReadData), 32'd0);
      check("midrst_alarm", 32'(alarm), 32'd0);
      check("midrst_scanDone", 32'(scanDone), 32'd0);
      check("midrst_scanCount", 32'(scanCount), 32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (80) @(negedge clk);
      check("midrst_no_scan", 32'(scanCount), 32'd0);
      run_scan("after_rst");
      check("after_rst_count", 32'(scanCount), 32'd1);
      check("after_rst_alarm", 32'(alarm), 32'b10);

      // Exactly at the limits: no alarm
      set_word(1, 0, 16'h4600);
      set_word(1, 4, 16'h0064);
      run_scan("limit_scan");
      check("alarm_clear", 32'(alarm), 32'b00);

      // Three refreshes during a scan give one follow-up scan
      #2 rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      pulse_updated();
      repeat (10) @(negedge clk);
      pulse_updated();
      repeat (20) @(negedge clk);
      pulse_updated();
      wait_done("merge_first", n);
      gap = 0;
      @(negedge clk);
      gap = 1;
      while (!scanDone && gap < 200) begin
         @(negedge clk);
         gap++;
      end
      check("merge_gap", 32'(gap), 32'd61);
      repeat (100) @(negedge clk);
      check("merge_count", 32'(scanCount), 32'd2);

      // Unused slots read zero
      host_read(4'hE, "slot6_zero", 16'h0000);
      host_read(4'hF, "slot7_zero", 16'h0000);
      host_read(4'h9, "m1_vcc", 16'h8000);

      // scanCount wrap from preloaded 16'hFFFF
      @(negedge clk);
      force dut.r_scan_count = 16'hFFFF;
      e_count = 16'hFFFF;
      @(negedge clk);
      release dut.r_scan_count;
      check("preload", 32'(scanCount), 32'hFFFF);
      run_scan("wrap_scan");
      check("wrap_done", 32'(scanDone), 32'd1);
      check("wrap_count", 32'(scanCount), 32'd0);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
